// File: rtl/pool_stream_unit.sv
// Streaming multi-channel pooling unit: every WINDOW_LEN accepted beats reduce to one
// registered max or floor-average result per lane, with valid/ready on both sides.

module pool_lane #(
    parameter int DATA_W   = 48,
    parameter int LOG2_WIN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic              first,
    input  logic              last,
    input  logic              avg_mode,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] res
);
    localparam int AW = DATA_W + LOG2_WIN;

    logic signed [AW-1:0]     acc;
    logic signed [AW-1:0]     x_ext;
    logic signed [AW-1:0]     max_v;
    logic signed [AW-1:0]     sum_v;
    logic signed [DATA_W-1:0] avg_res;
    logic signed [DATA_W-1:0] max_res;

    assign x_ext = {{LOG2_WIN{x[DATA_W-1]}}, x};
    assign max_v = (x_ext > acc) ? x_ext : acc;
    assign sum_v = acc + x_ext;
    // Window sum of WINDOW_LEN in-range samples always fits AW bits, and the
    // floored mean is back within DATA_W range, so truncation is lossless.
    assign avg_res = DATA_W'(sum_v >>> LOG2_WIN);
    assign max_res = DATA_W'(max_v);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (accept) begin
            if (first)
                acc <= x_ext;
            else if (!last)
                acc <= avg_mode ? sum_v : max_v;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            res <= '0;
        else if (accept && last)
            res <= avg_mode ? avg_res : max_res;
    end
endmodule

module pool_stream_unit #(
    parameter int DATA_W     = 48,
    parameter int CHANNELS   = 4,
    parameter int WINDOW_LEN = 4,
    parameter int LOG2_WIN   = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clear,
    input  logic                         i_mode,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [CHANNELS*DATA_W-1:0]   i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [CHANNELS*DATA_W-1:0]   o_data,
    output logic                         o_busy
);
    if ((1 << LOG2_WIN) != WINDOW_LEN || WINDOW_LEN < 2) begin : g_bad_win
        $error("WINDOW_LEN must be a power of 2 >= 2 and equal 2**LOG2_WIN");
    end

    typedef enum logic [1:0] {PH_FIRST, PH_ACCUM, PH_LAST} phase_t;

    logic [LOG2_WIN-1:0]               cnt, cnt_nxt;
    phase_t                            phase;
    logic                              accept;
    logic                              mode_q;
    logic                              is_first, is_last;
    logic [CHANNELS-1:0][DATA_W-1:0]   res_q;

    assign o_ready = !(o_valid && !i_ready);
    assign accept  = i_valid && o_ready && !i_clear;
    assign o_busy  = (cnt != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

    always_comb begin
        phase    = PH_ACCUM;
        cnt_nxt  = cnt;
        if (cnt == '0)
            phase = PH_FIRST;
        else if (cnt == LOG2_WIN'(WINDOW_LEN - 1))
            phase = PH_LAST;
        is_first = (phase == PH_FIRST);
        is_last  = (phase == PH_LAST);
        if (i_clear)
            cnt_nxt = '0;
        else if (accept)
            cnt_nxt = is_last ? '0 : cnt + LOG2_WIN'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            mode_q <= 1'b0;
        else if (accept && is_first)
            mode_q <= i_mode;
    end

    // A new result landing in the drain cycle keeps o_valid up: no bubble.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            o_valid <= 1'b0;
        else if (accept && is_last)
            o_valid <= 1'b1;
        else if (i_ready)
            o_valid <= 1'b0;
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        pool_lane #(
            .DATA_W   (DATA_W),
            .LOG2_WIN (LOG2_WIN)
        ) u_lane (
            .clk      (i_clk),
            .rst_n    (i_rst_n),
            .clear    (i_clear),
            .accept   (accept),
            .first    (is_first),
            .last     (is_last),
            .avg_mode (mode_q),
            .x        (i_data[k*DATA_W +: DATA_W]),
            .res      (res_q[k])
        );
    end

    assign o_data = res_q;
endmodule
